// File: rtl/kovacs_indicator_decoder.sv
// Kovacs feedback indicator decoder: classifies, debounces and order-checks the phase level and
// measures phase dwell. Optional illegal-transition counter enabled by KOVACS_DEC_ERRCNT_EN.
module kovacs_indicator_decoder #(
  parameter int unsigned        DEBOUNCE = 4,
  parameter logic signed [13:0] HI_THR   = 14'sd6144,
  parameter logic signed [13:0] LO_THR   = 14'sd2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [13:0] indicator_i,
  input  logic        enable_i,
  input  logic        clear_err_i,
  output logic [1:0]  state_o,
  output logic        state_valid_o,
  output logic        phase_end_o,
  output logic [1:0]  phase_id_o,
  output logic [31:0] phase_len_o,
  output logic        cycle_done_o,
  output logic        seq_err_o
`ifdef KOVACS_DEC_ERRCNT_EN
  ,
  output logic [15:0] err_count_o
`endif
);

  localparam logic [7:0] DebLimit = 8'(DEBOUNCE);

  typedef enum logic {StSync, StTrack} dec_state_e;

  dec_state_e  state_q, state_d;
  logic [13:0] sample_q;
  logic [1:0]  class_d, class_q, class_prev_q;
  logic [1:0]  pipe_vld_q;
  logic        loaded_q, loaded_d;
  logic [1:0]  level_q, level_d;
  logic [7:0]  run_q, run_d, run_next;
  logic [31:0] len_q, len_d, len_inc;
  logic        phase_end_q, phase_end_d;
  logic [1:0]  phase_id_q, phase_id_d;
  logic [31:0] phase_len_q, phase_len_d;
  logic        cycle_done_q, cycle_done_d;
  logic        seq_err_q, seq_err_d;
  logic        accept, illegal;

  function automatic logic is_legal(input logic [1:0] from, input logic [1:0] to);
    return ((from == 2'd0) && (to == 2'd2)) ||
           ((from == 2'd2) && (to == 2'd1)) ||
           ((from == 2'd1) && (to == 2'd0));
  endfunction

  always_comb begin
    class_d = 2'd2;
    if ($signed(sample_q) >= HI_THR) begin
      class_d = 2'd0;
    end else if ($signed(sample_q) >= LO_THR) begin
      class_d = 2'd1;
    end
  end

  // pipe_vld_q marks when class_q first holds a class derived from a post-reset sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q     <= '0;
      class_q      <= '0;
      class_prev_q <= '0;
      pipe_vld_q   <= '0;
    end else begin
      sample_q     <= indicator_i;
      class_q      <= class_d;
      class_prev_q <= class_q;
      pipe_vld_q   <= {pipe_vld_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    loaded_d     = loaded_q;
    run_d        = run_q;
    len_d        = len_q;
    phase_end_d  = 1'b0;
    cycle_done_d = 1'b0;
    phase_id_d   = phase_id_q;
    phase_len_d  = phase_len_q;
    seq_err_d    = seq_err_q & ~clear_err_i;
    run_next     = '0;
    accept       = 1'b0;
    illegal      = 1'b0;
    len_inc      = (len_q == '1) ? len_q : len_q + 32'd1;

    if (!loaded_q) begin
      if (pipe_vld_q[1]) begin
        level_d  = class_q;
        loaded_d = 1'b1;
      end
    end else if (!enable_i) begin
      state_d = StSync;
      run_d   = '0;
      len_d   = '0;
    end else begin
      // A change of class counts as the first cycle of the new candidate.
      if (class_q == level_q) begin
        run_next = '0;
      end else if ((class_q == class_prev_q) && (run_q != '0)) begin
        run_next = run_q + 8'd1;
      end else begin
        run_next = 8'd1;
      end
      accept = (run_next == DebLimit);
      run_d  = accept ? '0 : run_next;

      unique case (state_q)
        StSync: begin
          if (accept) begin
            level_d = class_q;
            state_d = StTrack;
            len_d   = '0;
          end
        end
        StTrack: begin
          if (accept) begin
            level_d     = class_q;
            phase_end_d = 1'b1;
            phase_id_d  = level_q;
            phase_len_d = len_inc;
            len_d       = '0;
            if (!is_legal(level_q, class_q)) begin
              illegal   = 1'b1;
              seq_err_d = 1'b1;
            end else if (level_q == 2'd1) begin
              cycle_done_d = 1'b1;
            end
          end else begin
            len_d = len_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StSync;
      level_q      <= '0;
      loaded_q     <= 1'b0;
      run_q        <= '0;
      len_q        <= '0;
      phase_end_q  <= 1'b0;
      phase_id_q   <= '0;
      phase_len_q  <= '0;
      cycle_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      loaded_q     <= loaded_d;
      run_q        <= run_d;
      len_q        <= len_d;
      phase_end_q  <= phase_end_d;
      phase_id_q   <= phase_id_d;
      phase_len_q  <= phase_len_d;
      cycle_done_q <= cycle_done_d;
      seq_err_q    <= seq_err_d;
    end
  end

`ifdef KOVACS_DEC_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // An increment in the same cycle as a clear takes priority over the clear.
  always_comb begin
    err_cnt_d = clear_err_i ? '0 : err_cnt_q;
    if (illegal) begin
      err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

  assign state_o       = level_q;
  assign state_valid_o = (state_q == StTrack);
  assign phase_end_o   = phase_end_q;
  assign phase_id_o    = phase_id_q;
  assign phase_len_o   = phase_len_q;
  assign cycle_done_o  = cycle_done_q;
  assign seq_err_o     = seq_err_q;

endmodule

// File: doc/kovacs_indicator_decoder.md
# kovacs_indicator_decoder

Receive-side decoder for the three-phase Kovacs feedback protocol. It samples the 14-bit protocol indicator level (8191 = feedback, 4096 = rescaled feedback, 0 = off) returned through an ADC channel. It debounces the sampled level into a phase state, checks that phases arrive in the legal order, and measures each phase's duration in clock cycles. It sits on the acquisition side of the Red Pitaya design and feeds phase tags and dwell-time measurements to the logging/readout logic.

## Interface
- DEBOUNCE, 4: consecutive classified samples required to accept a level change; legal range 1..255.
- HI_THR, 6144: signed 14-bit threshold; samples ≥ HI_THR classify as phase 0 (feedback).
- LO_THR, 2048: signed 14-bit threshold; samples ≥ LO_THR and < HI_THR classify as phase 1 (rescaled); samples < LO_THR classify as phase 2 (off).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- indicator_i  in  14  indicator sample, signed two's complement.
- enable_i  in  1  decoder enable; low forces SYNC.
- clear_err_i  in  1  clears seq_err_o (and the error count when enabled).
- state_o  out  2  accepted phase (0/1/2).
- state_valid_o  out  1  high while in TRACK.
- phase_end_o  out  1  one-cycle strobe: a fully observed phase ended.
- phase_id_o  out  2  id of the phase that ended; held until the next strobe.
- phase_len_o  out  32  length of that phase in cycles; held until the next strobe.
- cycle_done_o  out  1  one-cycle strobe on a legal 1→0 transition.
- seq_err_o  out  1  sticky illegal-order flag.
- err_count_o  out  16  illegal transition count; present only with the macro.

## Operation
- Pipeline: indicator_i is registered. It is then classified with signed compares and the class is registered.
- Debounce: run counter counts consecutive cycles where class differs from the accepted level and is unchanged. Counter resets when class equals the accepted level or changes value. When it reaches DEBOUNCE, the accepted level takes the class value, which is a transition.
- Legal successors: 0→2, 2→1, 1→0.
- FSM SYNC: state_valid_o=0 and no strobes. After reset, the accepted level is loaded from the first registered class with no transition. The first transition enters TRACK and zeroes the length counter. The partial first phase is never reported.
- FSM TRACK, on each transition:
  - phase_end_o=1, phase_id_o = old level, phase_len_o = length counter + 1; the counter restarts at 0.
  - Illegal successor: seq_err_o set, and tracking continues from the new level.
  - Legal 1→0: cycle_done_o=1 in the same cycle as phase_end_o.
- Length counter increments every TRACK cycle and saturates at 0xFFFFFFFF. A saturated value is reported as 0xFFFFFFFF.
- enable_i low: return to SYNC, clear run counter and length counter; seq_err_o is retained.
- clear_err_i: clears seq_err_o the next cycle. If an error occurs in the same cycle, set wins.

## Timing
- Reset values: state_o=0, state_valid_o=0, phase_end_o=0, phase_id_o=0, phase_len_o=0, cycle_done_o=0, seq_err_o=0, err_count_o=0.
- Latency: first sample of a new level at indicator_i → state_o update and phase_end_o strobe = DEBOUNCE+2 cycles.
- Debounce delay is identical on both edges, so phase_len_o equals the true input dwell length.
- Strobes are single-cycle; a transition is accepted at most once every DEBOUNCE cycles.
- Reset mid-phase discards all in-flight measurement; no strobe is emitted on reset.

## Configuration
- KOVACS_DEC_ERRCNT_EN defined:
  - err_count_o exists.
  - It increments on every illegal transition and saturates at 0xFFFF.
  - It is cleared by rst_i or clear_err_i; increment wins over a simultaneous clear.
- Undefined: the err_count_o port and its counter are absent; all other behaviour is unchanged.

## Test plan
- Reset mid-TRACK: assert rst_i → next cycle all outputs at reset values. Strobes appear only after a new SYNC→TRACK transition.
- Clean sequence, DEBOUNCE=4: drive 8191×100, 0×50, 4096×100, 8191×100.
  - Required: id=2/len=50, then id=1/len=100 together with cycle_done_o.
  - Each strobe occurs 6 cycles after its input edge; seq_err_o stays 0.
- Glitch: inside an 8191 phase, inject 0 for 3 cycles → no transition. Inject 0 for 4 cycles → transition accepted.
- Illegal order: 8191 then 4096 → phase_end_o with id=0, seq_err_o=1, plus err_count_o=1 when the macro is on. Pulse clear_err_i → seq_err_o=0.
- Thresholds: 6144→0, 6143→1, 2048→1, 2047→2, -100→2. Each value is held for 10 cycles.
- enable_i low for 1 cycle mid-phase → state_valid_o=0, no strobe. The first strobe after re-sync reports only a fully observed phase.
